// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: operation codes and burst FSM states.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_SL    = 3'd1,
    OP_SR    = 3'd2,
    OP_ROL   = 3'd3,
    OP_ROR   = 3'd4,
    OP_LOAD  = 3'd5,
    OP_CLEAR = 3'd6,
    OP_ASR   = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/univ_shift_reg_if.sv
// Command/status bundle of the universal shift register.
// Optional macro SHREG_PARITY_EN adds the registered parity status bit.
interface univ_shift_reg_if
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  op_t              op;
  logic             din;
  logic [WIDTH-1:0] pdin;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] Q;
  logic             sout_l;
  logic             sout_r;
  logic             busy;
  logic             done;
`ifdef SHREG_PARITY_EN
  logic             parity;
`endif

  modport master (
    output op, din, pdin, start, count,
`ifdef SHREG_PARITY_EN
    input  parity,
`endif
    input  Q, sout_l, sout_r, busy, done
  );

  modport slave (
    input  op, din, pdin, start, count,
`ifdef SHREG_PARITY_EN
    output parity,
`endif
    output Q, sout_l, sout_r, busy, done
  );

endinterface

// File: rtl/univ_shift_reg_shift_step.sv
// Combinational next-value function of the shift register, shared by the
// streaming and burst paths.
module shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_t              op,
  input  logic             din,
  input  logic [WIDTH-1:0] pdin,
  output logic [WIDTH-1:0] q_next
);

  // Select the next register value for the requested operation.
  always_comb begin
    q_next = q;
    case (op)
      OP_HOLD:  q_next = q;
      OP_SL:    q_next = {q[WIDTH-2:0], din};
      OP_SR:    q_next = {din, q[WIDTH-1:1]};
      OP_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      OP_ROR:   q_next = {q[0], q[WIDTH-1:1]};
      OP_LOAD:  q_next = pdin;
      OP_CLEAR: q_next = '0;
      OP_ASR:   q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      default:  q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with streaming mode and counted bursts (busy/done).
// Optional macro SHREG_PARITY_EN adds a registered parity output coherent with Q.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  univ_shift_reg_if.slave bus
);

  state_t           state_q;
  op_t              op_q;
  logic [CNT_W-1:0] remaining_q;
  logic [WIDTH-1:0] q_reg;
  logic             busy_q;
  logic             done_q;
  op_t              step_op;
  logic             apply_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_d;
`ifdef SHREG_PARITY_EN
  logic             parity_q;
`endif

  // A running burst uses its latched op; otherwise the live op is applied,
  // except for a zero-length burst, which leaves Q untouched.
  always_comb begin
    step_op    = (state_q == S_RUN) ? op_q : bus.op;
    apply_step = 1'b1;
    if (state_q == S_IDLE && bus.start && bus.count == '0)
      apply_step = 1'b0;
  end

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q      (q_reg),
    .op     (step_op),
    .din    (bus.din),
    .pdin   (bus.pdin),
    .q_next (q_step)
  );

  assign q_d = apply_step ? q_step : q_reg;

  // Register update plus burst FSM; reset aborts any burst without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_reg       <= '0;
      state_q     <= S_IDLE;
      op_q        <= OP_HOLD;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SHREG_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      q_reg  <= q_d;
      done_q <= 1'b0;
`ifdef SHREG_PARITY_EN
      parity_q <= ^q_d;
`endif
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.count == '0) begin
              done_q <= 1'b1;
            end else begin
              op_q        <= bus.op;
              remaining_q <= bus.count - CNT_W'(1);
              if (bus.count == CNT_W'(1)) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          remaining_q <= remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.Q      = q_reg;
  assign bus.sout_l = q_reg[WIDTH-1];
  assign bus.sout_r = q_reg[0];
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
`ifdef SHREG_PARITY_EN
  assign bus.parity = parity_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;
  import univ_shift_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = OP_HOLD;
    bus.din   = 1'b0;
    bus.count = '0;
    bus.pdin  = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.op   = OP_LOAD;
    bus.pdin = 8'hFF;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state Q=%h busy=%b done=%b required Q=00 busy=0 done=0", bus.Q, bus.busy, bus.done);
    end
    checks++;
    if (bus.sout_l !== 1'b0 || bus.sout_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_taps sout_l=%b sout_r=%b required 0 0", bus.sout_l, bus.sout_r);
    end
`ifdef SHREG_PARITY_EN
    checks++;
    if (bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL reset_parity got %b required 0", bus.parity);
    end
`endif
  endtask

  task automatic test_load_and_zero_count();
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 1; bus.pdin = 8'hA5;
    tick();
    idle_inputs();
    checks++;
    if (bus.Q !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_count1 Q=%h done=%b busy=%b required Q=a5 done=1 busy=0", bus.Q, bus.done, bus.busy);
    end
`ifdef SHREG_PARITY_EN
    checks++;
    if (bus.parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_a5 got %b required 0", bus.parity);
    end
`endif
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.Q !== 8'hA5) begin
      errors++;
      $display("FAIL load_done_drop done=%b Q=%h required done=0 Q=a5", bus.done, bus.Q);
    end
    // zero-length burst with a LOAD op must not touch Q
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 0; bus.pdin = 8'hFF;
    tick();
    idle_inputs();
    checks++;
    if (bus.Q !== 8'hA5 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL count0 Q=%h done=%b busy=%b required Q=a5 done=1 busy=0", bus.Q, bus.done, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL count0_pulse done=%b required 0", bus.done);
    end
  endtask

  task automatic test_rotate_burst();
    logic [7:0] exp_q [3];
    logic       exp_busy [3];
    logic       exp_done [3];
    exp_q    = '{8'h4B, 8'h96, 8'h2D};
    exp_busy = '{1'b1, 1'b1, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b1};
    bus.start = 1'b1; bus.op = OP_ROL; bus.count = 3;
    for (int i = 0; i < 3; i++) begin
      tick();
      idle_inputs();
      checks++;
      if (bus.Q !== exp_q[i] || bus.busy !== exp_busy[i] || bus.done !== exp_done[i]) begin
        errors++;
        $display("FAIL rol_step%0d Q=%h busy=%b done=%b required Q=%h busy=%b done=%b",
                 i, bus.Q, bus.busy, bus.done, exp_q[i], exp_busy[i], exp_done[i]);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.Q !== 8'h2D) begin
      errors++;
      $display("FAIL rol_after done=%b Q=%h required done=0 Q=2d", bus.done, bus.Q);
    end
  endtask

  // Load a start value, run a burst, and measure edges until done.
  task automatic run_burst(input op_t op, input logic [7:0] init, input int n,
                           input logic [7:0] exp, input string name);
    int cycles;
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 1; bus.pdin = init;
    tick();
    bus.start = 1'b1; bus.op = op; bus.count = n[CNT_W-1:0]; bus.din = 1'b0;
    tick();
    cycles = 1;
    // live inputs change during the burst and must be ignored
    bus.start = 1'b1; bus.op = OP_CLEAR; bus.count = 1; bus.pdin = 8'h00;
    while (bus.done !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    idle_inputs();
    checks++;
    if (cycles != n || bus.Q !== exp) begin
      errors++;
      $display("FAIL %s cycles=%0d Q=%h required cycles=%0d Q=%h", name, cycles, bus.Q, n, exp);
    end
    tick();
  endtask

  task automatic test_shift_modes();
    run_burst(OP_ASR, 8'h80, 7, 8'hFF, "asr_burst");
    run_burst(OP_SR,  8'h80, 7, 8'h01, "sr_burst");
    run_burst(OP_ROR, 8'h5A, 8, 8'h5A, "ror_full_turn");
    run_burst(OP_ROL, 8'h81, 9, 8'h03, "rol_over_width");
  endtask

  task automatic test_streaming();
    logic seen_done;
    seen_done = 1'b0;
    bus.op = OP_CLEAR;
    tick();
    bus.op = OP_SL; bus.din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_done |= bus.done;
    end
    checks++;
    if (bus.Q !== 8'h07 || seen_done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_sl Q=%h done_seen=%b busy=%b required Q=07 done_seen=0 busy=0", bus.Q, seen_done, bus.busy);
    end
    bus.op = OP_CLEAR;
    tick();
    bus.op = OP_SR; bus.din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen_done |= bus.done;
    end
    idle_inputs();
    checks++;
    if (bus.Q !== 8'hE0 || seen_done !== 1'b0) begin
      errors++;
      $display("FAIL stream_sr Q=%h done_seen=%b required Q=e0 done_seen=0", bus.Q, seen_done);
    end
    checks++;
    if (bus.sout_l !== 1'b1 || bus.sout_r !== 1'b0) begin
      errors++;
      $display("FAIL stream_taps sout_l=%b sout_r=%b required 1 0", bus.sout_l, bus.sout_r);
    end
`ifdef SHREG_PARITY_EN
    checks++;
    if (bus.parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_e0 got %b required 1", bus.parity);
    end
`endif
  endtask

  task automatic test_mid_burst();
    logic seen_done;
    seen_done = 1'b0;
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 1; bus.pdin = 8'h01;
    tick();
    bus.start = 1'b1; bus.op = OP_ROR; bus.count = 8;
    tick();                                  // edge 1: Q=80
    bus.start = 1'b1; bus.op = OP_CLEAR; bus.count = 1;
    tick();                                  // edge 2: CLEAR ignored, Q=40
    idle_inputs();
    seen_done |= bus.done;
    checks++;
    if (bus.Q !== 8'h40 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_ignore Q=%h busy=%b required Q=40 busy=1", bus.Q, bus.busy);
    end
    tick();                                  // edge 3: Q=20
    seen_done |= bus.done;
    reset = 1'b1;
    tick();                                  // edge 4: reset
    reset = 1'b0;
    seen_done |= bus.done;
    checks++;
    if (bus.Q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset Q=%h busy=%b done=%b required Q=00 busy=0 done=0", bus.Q, bus.busy, bus.done);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      seen_done |= bus.done;
    end
    checks++;
    if (seen_done !== 1'b0 || bus.Q !== 8'h00) begin
      errors++;
      $display("FAIL mid_no_done done_seen=%b Q=%h required done_seen=0 Q=00", seen_done, bus.Q);
    end
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 1; bus.pdin = 8'h3C;
    tick();
    idle_inputs();
    checks++;
    if (bus.Q !== 8'h3C || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_start Q=%h done=%b required Q=3c done=1", bus.Q, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    // two-step LOAD burst re-samples pdin each step, then a new burst right away
    bus.start = 1'b1; bus.op = OP_LOAD; bus.count = 2; bus.pdin = 8'h11;
    tick();
    bus.start = 1'b0; bus.pdin = 8'h22;
    tick();
    checks++;
    if (bus.Q !== 8'h22 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL load_resample Q=%h done=%b required Q=22 done=1", bus.Q, bus.done);
    end
    bus.start = 1'b1; bus.op = OP_SL; bus.count = 2; bus.din = 1'b1;
    tick();
    bus.start = 1'b0; bus.din = 1'b0;
    tick();
    idle_inputs();
    checks++;
    if (bus.Q !== 8'h8A || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sl Q=%h done=%b busy=%b required Q=8a done=1 busy=0", bus.Q, bus.done, bus.busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    idle_inputs();
    tick();
    reset = 1'b0;
    test_reset();
    test_load_and_zero_count();
    test_rotate_burst();
    test_shift_modes();
    test_streaming();
    test_mid_burst();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register; generational successor to the fixed 8-bit left/right shifter.
- Adds width generality, rotate, arithmetic-shift, parallel load and clear.
- Adds a counted burst mode with busy/done handshake.
- Sits in the datapath as a serialiser/deserialiser and bit-manipulation unit; drives serial-out taps for chaining.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- CNT_W, $clog2(WIDTH)+1, width of the burst count input.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- op  in  3  operation code; see Behaviour.
- din  in  1  serial input bit for SL/SR, sampled every cycle the op executes.
- pdin  in  WIDTH  parallel load data.
- start  in  1  burst command strobe; sampled only while idle.
- count  in  CNT_W  number of burst steps, latched on start.
- Q  out  WIDTH  register contents (registered).
- sout_l  out  1  Q[WIDTH-1].
- sout_r  out  1  Q[0].
- busy  out  1  burst in progress (registered).
- done  out  1  one-cycle burst-completion pulse (registered).

Behaviour:
- Op codes:
  - 0 HOLD.
  - 1 SL: Q <= {Q[W-2:0], din}.
  - 2 SR: Q <= {din, Q[W-1:1]}.
  - 3 ROL: Q <= {Q[W-2:0], Q[W-1]}.
  - 4 ROR: Q <= {Q[0], Q[W-1:1]}.
  - 5 LOAD: Q <= pdin.
  - 6 CLEAR: Q <= 0.
  - 7 ASR: Q <= {Q[W-1], Q[W-1:1]}.
- Reset (synchronous, on the clk edge with reset=1): Q=0, busy=0, done=0, state=IDLE, remaining=0. Reset overrides everything, including mid-burst.
- FSM states: IDLE, RUN.
- IDLE, start=0 (streaming mode): op applied on every edge; busy=0; done=0.
- IDLE, start=1, count>=1:
  - op is latched into op_q and the first step is performed on the same edge.
  - remaining <= count-1.
  - If count==1: stay in IDLE and set done=1 on that edge.
  - Else: go to RUN and set busy=1.
- IDLE, start=1, count==0: Q unchanged; done=1 on that edge; stay in IDLE.
- LOAD, CLEAR and HOLD with start behave as bursts. Repeated LOAD re-samples pdin each step.
- RUN:
  - Each edge applies op_q; din is re-sampled each cycle for SL/SR.
  - remaining is decremented on each edge.
  - When remaining==1 at the edge: perform the final step, set done=1 and busy=0, and return to IDLE.
- Ignored inputs in RUN: op, start, count and pdin (except LOAD) are ignored.
- Latency: a burst of N steps completes N edges after the start edge.
  - done is observed high in the same cycle Q shows the final value.
  - busy is high for N-1 cycles.
- done: high for exactly one cycle. It is never asserted in streaming mode.
- Counts above WIDTH are legal (up to 2^CNT_W-1). ROL/ROR by WIDTH steps returns the original value.

Optional Feature:
Macro: SHREG_PARITY_EN.
- Defined: adds output port parity (1 bit), registered, equal to the XOR-reduction of the next value of Q, so that it is always coherent with Q. Reset value is 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package univ_shift_pkg:
  - op_t enum (OP_HOLD ... OP_ASR, 3 bits).
  - state_t enum (S_IDLE, S_RUN).
- Sub-module shift_step:
  - Combinational next-value function (WIDTH param).
  - Inputs: q, op, din, pdin. Output: q_next.
  - Shared by streaming and burst paths.
- Top-level content: FSM, remaining counter, registers.

Test Plan (WIDTH=8):
- Reset: assert reset for 1 edge with arbitrary prior state -> Q=8'h00, busy=0, done=0; sout_l=sout_r=0.
- Load and count==0:
  - start, op=LOAD, count=1, pdin=8'hA5 -> Q=8'hA5 after 1 edge, done pulse coincident, busy never high.
  - Then start, count=0 -> Q stays 8'hA5, done pulses once.
- Rotate burst: Q=8'hA5, start, op=ROL, count=3 -> Q=8'h4B, 8'h96, then 8'h2D. busy high for 2 cycles; done high only with Q=8'h2D.
- Arithmetic vs logical shift:
  - Q=8'h80, ASR, count=7 -> Q=8'hFF.
  - Q=8'h80, SR, din=0, count=7 -> Q=8'h01.
- Streaming: Q=0, start=0, op=SL, din=1 for 3 edges -> Q=8'h07, done never asserted. Then op=SR, din=1 from 0 for 3 edges -> Q=8'hE0.
- Mid-burst behaviour: start ROR, count=8 from 8'h01.
  - A start with op=CLEAR at edge 2 is ignored.
  - reset at edge 4 -> Q=0, busy=0, no done pulse.
  - A new start afterwards is accepted normally.
